// File: rtl/ctrl_pkg.sv
// Shared definitions for the counter sequencing controller: FSM state
// encoding, count boundary values and the control payload driven to the
// cascaded units/tens counters.
package ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [NIB_W-1:0] UP_LIMIT = 4'hF;
    localparam logic [NIB_W-1:0] DN_LIMIT = 4'h0;

    // Control bundle shared by both counter instances.
    typedef struct packed {
        logic en_units;
        logic en_tens;
        logic forward;
        logic cnt_clr;
    } cnt_ctrl_t;

    // Digit value at which a counter carries (up) or borrows (down).
    function automatic logic [NIB_W-1:0] boundary(input logic fwd);
        return fwd ? UP_LIMIT : DN_LIMIT;
    endfunction

endpackage : ctrl_pkg

// File: rtl/tick_prescaler.sv
// Free-running prescaler that produces one count tick every PRESCALE cycles
// while run is high, holds while run is low, and restarts from zero on load0.
// Ports:
//   clk    - system clock
//   reset  - asynchronous, active-low reset
//   run    - advance the prescaler this cycle
//   load0  - force the prescaler to zero (wins over run)
//   tick   - high in the cycle the prescaler sits at its top value while running
module tick_prescaler
    import ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic load0,
    output logic tick
);

    localparam int unsigned PW = $clog2(PRESCALE);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          at_top_c;

    assign at_top_c = (presc_q == PW'(PRESCALE - 1));
    assign tick     = run & at_top_c;

    // Next prescaler value: clear, wrap on tick, increment, or hold.
    always_comb begin
        presc_d = presc_q;
        if (load0) begin
            presc_d = '0;
        end else if (run) begin
            presc_d = at_top_c ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_prescaler

// File: rtl/counter_seq_ctrl.sv
// Sequencer for a pair of cascaded 4-bit hex up/down counters (units, tens).
// Converts start/pause, clear and direction pulses plus a prescaled tick
// into registered enable, direction and synchronous-clear controls, and
// handles carry/borrow into tens and the one-shot stop at the terminal value.
// Ports:
//   clk, reset           - clock and asynchronous active-low reset
//   start_btn            - pulse, toggles run/pause
//   clear_btn            - pulse, clears counters and returns to idle
//   dir_btn              - pulse, toggles count direction
//   oneshot              - level, stop at terminal value instead of wrapping
//   units_val, tens_val  - current counter values
//   en_units, en_tens    - one-cycle counter enables
//   forward              - count direction (1 = up)
//   cnt_clr              - synchronous clear to both counters
//   running, done        - state indicators
module counter_seq_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_btn,
    input  logic             clear_btn,
    input  logic             dir_btn,
    input  logic             oneshot,
    input  logic [NIB_W-1:0] units_val,
    input  logic [NIB_W-1:0] tens_val,
    output logic             en_units,
    output logic             en_tens,
    output logic             forward,
    output logic             cnt_clr,
    output logic             running,
    output logic             done
);

    state_e    state_q;
    state_e    state_d;
    cnt_ctrl_t ctrl_q;
    cnt_ctrl_t ctrl_d;
    logic      dir_pending_q;
    logic      dir_pending_d;
    logic      running_q;
    logic      running_d;
    logic      done_q;
    logic      done_d;

    logic             tick_c;
    logic             run_c;
    logic             load0_c;
    logic             tick_act_c;
    logic             dir_req_c;
    logic [NIB_W-1:0] bnd_c;
    logic             units_bnd_c;
    logic             terminal_c;

    assign run_c   = (state_q == S_RUN);
    // Prescaler restarts from zero when idle, done, or on clear.
    assign load0_c = clear_btn | (state_q == S_IDLE) | (state_q == S_DONE);

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run_c),
        .load0 (load0_c),
        .tick  (tick_c)
    );

    // A tick is only acted on in RUN and never alongside a clear.
    assign tick_act_c  = tick_c & run_c & ~clear_btn;
    assign bnd_c       = boundary(ctrl_q.forward);
    assign units_bnd_c = (units_val == bnd_c);
    assign terminal_c  = units_bnd_c & (tens_val == bnd_c);
    // Pending request after this cycle's button; two presses cancel out.
    assign dir_req_c   = dir_pending_q ^ dir_btn;

    // Next-state and registered-output logic.
    always_comb begin
        state_d          = state_q;
        ctrl_d           = ctrl_q;
        ctrl_d.en_units  = 1'b0;
        ctrl_d.en_tens   = 1'b0;
        ctrl_d.cnt_clr   = 1'b0;
        dir_pending_d    = dir_req_c;

        // Direction only changes on edges with no enable pulse being issued,
        // so each enable pulse is paired with a stable forward value.
        if (dir_req_c && !tick_act_c) begin
            ctrl_d.forward = ~ctrl_q.forward;
            dir_pending_d  = 1'b0;
        end

        if (clear_btn) begin
            ctrl_d.cnt_clr = 1'b1;
            state_d        = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_btn) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (start_btn) begin
                        state_d = S_PAUSE;
                    end
                    if (tick_c) begin
                        if (oneshot && terminal_c) begin
                            state_d = S_DONE;
                        end else begin
                            ctrl_d.en_units = 1'b1;
                            ctrl_d.en_tens  = units_bnd_c;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_btn) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            ctrl_q        <= '{en_units: 1'b0, en_tens: 1'b0, forward: 1'b1, cnt_clr: 1'b1};
            dir_pending_q <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_q        <= ctrl_d;
            dir_pending_q <= dir_pending_d;
            running_q     <= running_d;
            done_q        <= done_d;
        end
    end

    assign en_units = ctrl_q.en_units;
    assign en_tens  = ctrl_q.en_tens;
    assign forward  = ctrl_q.forward;
    assign cnt_clr  = ctrl_q.cnt_clr;
    assign running  = running_q;
    assign done     = done_q;

endmodule : counter_seq_ctrl

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with PRESCALE=4.
// Output vectors are packed as {en_units, en_tens, forward, cnt_clr, running, done}.
module tb_counter_seq_ctrl;

    localparam int unsigned PRESCALE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_btn;
    logic       clear_btn;
    logic       dir_btn;
    logic       oneshot;
    logic [3:0] units_val;
    logic [3:0] tens_val;
    logic       en_units;
    logic       en_tens;
    logic       forward;
    logic       cnt_clr;
    logic       running;
    logic       done;

    always #5 clk = ~clk;

    counter_seq_ctrl #(
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_btn (start_btn),
        .clear_btn (clear_btn),
        .dir_btn   (dir_btn),
        .oneshot   (oneshot),
        .units_val (units_val),
        .tens_val  (tens_val),
        .en_units  (en_units),
        .en_tens   (en_tens),
        .forward   (forward),
        .cnt_clr   (cnt_clr),
        .running   (running),
        .done      (done)
    );

    typedef struct {
        string      name;
        logic       st;
        logic       cl;
        logic       dr;
        logic       os;
        logic [3:0] u;
        logic [3:0] t;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input string name, input logic st, input logic cl,
                                input logic dr, input logic os, input logic [3:0] u,
                                input logic [3:0] t, input logic eu, input logic et,
                                input logic fw, input logic clr, input logic run,
                                input logic dn);
        vec_t v;
        v.name = name;
        v.st   = st;
        v.cl   = cl;
        v.dr   = dr;
        v.os   = os;
        v.u    = u;
        v.t    = t;
        v.exp  = {eu, et, fw, clr, run, dn};
        return v;
    endfunction

    function automatic void add(input string name, input logic st, input logic cl,
                                input logic dr, input logic os, input logic [3:0] u,
                                input logic [3:0] t, input logic eu, input logic et,
                                input logic fw, input logic clr, input logic run,
                                input logic dn);
        vecs.push_back(mk(name, st, cl, dr, os, u, t, eu, et, fw, clr, run, dn));
    endfunction

    function automatic logic [5:0] outs();
        return {en_units, en_tens, forward, cnt_clr, running, done};
    endfunction

    task automatic expect_now(input string name, input logic [5:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        sb_t        e;
        logic [5:0] got;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: got no expectation for output %b", outs());
        end else begin
            e   = sb.pop_front();
            got = outs();
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %b required %b (eu,et,fw,clr,run,done) at %0t",
                         e.name, got, e.exp, $time);
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check after the next rising edge.
    task automatic apply(input vec_t v);
        start_btn = v.st;
        clear_btn = v.cl;
        dir_btn   = v.dr;
        oneshot   = v.os;
        units_val = v.u;
        tens_val  = v.t;
        expect_now(v.name, v.exp);
        @(posedge clk);
        @(negedge clk);
        check_pop();
        start_btn = 1'b0;
        clear_btn = 1'b0;
        dir_btn   = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        dir_btn   = 1'b0;
        oneshot   = 1'b0;
        units_val = 4'h7;
        tens_val  = 4'h0;

        // Basic counting from a start at edge 0.
        add("idle_after_rst", 0, 0, 0, 0, 4'h7, 4'h0, 0, 0, 1, 0, 0, 0);
        add("start",          1, 0, 0, 0, 4'h7, 4'h0, 0, 0, 1, 0, 1, 0);
        for (int k = 1; k <= 12; k++)
            add("count_u7", 0, 0, 0, 0, 4'h7, 4'h0, (k % 4 == 0), 0, 1, 0, 1, 0);
        // Carry up and borrow down.
        for (int k = 13; k <= 16; k++)
            add("carry_up", 0, 0, 0, 0, 4'hF, 4'h3, (k == 16), (k == 16), 1, 0, 1, 0);
        add("dir_to_down", 0, 0, 1, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("down_wait",   0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("down_wait",   0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("borrow_down", 0, 0, 0, 0, 4'h0, 4'h5, 1, 1, 0, 0, 1, 0);
        // Direction change coincident with a tick, then a cancelled pair.
        add("dir_to_up",    0, 0, 1, 0, 4'h7, 4'h5, 0, 0, 1, 0, 1, 0);
        add("up_wait",      0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 1, 0, 1, 0);
        add("up_wait",      0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 1, 0, 1, 0);
        add("dir_on_tick",  0, 0, 1, 0, 4'h7, 4'h5, 1, 0, 1, 0, 1, 0);
        add("dir_applied",  0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dn_wait",      0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dn_wait",      0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dir_cancel_a", 0, 0, 1, 0, 4'h7, 4'h5, 1, 0, 0, 0, 1, 0);
        add("dir_cancel_b", 0, 0, 1, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dir_cancel_c", 0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dir_cancel_d", 0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0);
        add("dir_cancel_e", 0, 0, 0, 0, 4'h7, 4'h5, 1, 0, 0, 0, 1, 0);
        // Clear retains direction.
        add("clear_run",     0, 1, 0, 0, 4'h7, 4'h5, 0, 0, 0, 1, 0, 0);
        add("clear_release", 0, 0, 0, 0, 4'h7, 4'h5, 0, 0, 0, 0, 0, 0);
        // Pause at edge 2, resume at edge 10, then start coincident with tick.
        for (int p = 0; p <= 21; p++) begin
            logic st;
            logic run;
            logic eu;
            st  = (p == 0 || p == 2 || p == 10 || p == 16 || p == 17);
            run = !((p >= 2 && p <= 9) || p == 16);
            eu  = (p == 12 || p == 16 || p == 21);
            add("pause_seq", st, 0, 0, 0, 4'h7, 4'h5, eu, 0, 0, 0, run, 0);
        end
        add("clear2",   0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 0, 1, 0, 0);
        add("dir_idle", 0, 0, 1, 0, 4'hF, 4'hF, 0, 0, 1, 0, 0, 0);
        // One-shot stop at FF, start ignored, clear leaves DONE.
        add("start_os", 1, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++)
            add("os_wait", 0, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 1, 0);
        add("oneshot_done",      0, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0, 1);
        add("done_ignore_start", 1, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0, 1);
        add("done_hold",         0, 0, 0, 1, 4'hF, 4'hF, 0, 0, 1, 0, 0, 1);
        add("done_clear",        0, 1, 0, 1, 4'hF, 4'hF, 0, 0, 1, 1, 0, 0);
        add("after_clear",       0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 0, 0, 0);
        // Wrap at FF when one-shot is off; one-shot with non-terminal carry.
        add("start_wrap", 1, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++)
            add("wrap_wait", 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 0, 1, 0);
        add("wrap_ff", 0, 0, 0, 0, 4'hF, 4'hF, 1, 1, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++)
            add("os_nonterm_wait", 0, 0, 0, 1, 4'hF, 4'h3, 0, 0, 1, 0, 1, 0);
        add("os_nonterm_carry", 0, 0, 0, 1, 4'hF, 4'h3, 1, 1, 1, 0, 1, 0);

        // Reset held low.
        @(negedge clk);
        expect_now("reset_held_a", 6'b001100);
        check_pop();
        @(negedge clk);
        expect_now("reset_held_b", 6'b001100);
        check_pop();
        reset = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // Clear coincident with a tick suppresses the enables.
        for (int k = 0; k < 3; k++)
            apply(mk("clr_tick_wait", 0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 1, 0, 1, 0));
        apply(mk("clr_on_tick", 0, 1, 0, 0, 4'hF, 4'hF, 0, 0, 1, 1, 0, 0));

        // Asynchronous reset while an enable pulse is high.
        apply(mk("ar_dir",   0, 0, 1, 0, 4'h7, 4'h0, 0, 0, 0, 0, 0, 0));
        apply(mk("ar_start", 1, 0, 0, 0, 4'h7, 4'h0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++)
            apply(mk("ar_wait", 0, 0, 0, 0, 4'h7, 4'h0, 0, 0, 0, 0, 1, 0));
        apply(mk("ar_tick", 0, 0, 0, 0, 4'h7, 4'h0, 1, 0, 0, 0, 1, 0));
        #2;
        reset = 1'b0;
        #1;
        expect_now("async_reset_now", 6'b001100);
        check_pop();
        @(negedge clk);
        expect_now("async_reset_hold", 6'b001100);
        check_pop();
        reset = 1'b1;
        apply(mk("async_reset_release", 0, 0, 0, 0, 4'h7, 4'h0, 0, 0, 1, 0, 0, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_counter_seq_ctrl

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Controller that sequences a pair of cascaded 4-bit hex up/down counters (units, tens) that feed the 7-segment display.
- Turns user pulses (start/pause, clear, direction, mode) plus a prescaled tick into the counters' enable, forward and synchronous-clear controls.
- Handles the units-to-tens carry/borrow and the one-shot stop at the terminal value.
- Sits between the button debouncers and the two counter instances.

Parameters:
- PRESCALE, 50000000, clk cycles per count tick (1 Hz at 50 MHz). Legal range is 2 or more.
- PW, $clog2(PRESCALE), prescaler width. Derived; never overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start_btn  in  1  1-cycle pulse; toggles run/pause
- clear_btn  in  1  1-cycle pulse; clears counters and returns to IDLE
- dir_btn  in  1  1-cycle pulse; toggles count direction
- oneshot  in  1  level; 1 = stop at terminal value, 0 = wrap
- units_val  in  4  current units counter value
- tens_val  in  4  current tens counter value
- en_units  out  1  units counter enable, 1-cycle pulse
- en_tens  out  1  tens counter enable, 1-cycle pulse
- forward  out  1  count direction to both counters (1 = up)
- cnt_clr  out  1  active-high synchronous clear to both counters
- running  out  1  high in RUN
- done  out  1  high in DONE

Behaviour:
- All outputs are registered.
- Reset values: en_units=0, en_tens=0, forward=1, cnt_clr=1, running=0, done=0, prescaler=0, dir_pending=0, state=IDLE.
- cnt_clr drops to 0 on the first clk edge after reset releases.
- States are IDLE, RUN, PAUSE, DONE.
- IDLE:
  - start_btn -> RUN; prescaler loads 0.
- RUN:
  - Prescaler increments each cycle. tick = (prescaler == PRESCALE-1); the prescaler wraps to 0 on tick.
  - start_btn -> PAUSE.
- PAUSE:
  - Prescaler holds its value.
  - start_btn -> RUN and resumes from the held value.
- DONE:
  - Prescaler held at 0.
  - start_btn is ignored; only clear_btn leaves DONE.
- clear_btn has priority over everything in every state:
  - cnt_clr=1 for exactly one cycle, prescaler=0, state -> IDLE.
  - Enables are forced to 0 that cycle.
  - Direction is retained.
- On tick in RUN, the boundary value is 15 when forward=1 and 0 when forward=0.
  - Terminal: units_val and tens_val are both at the boundary value.
  - If oneshot=1 and terminal: no enables issued, state -> DONE.
  - Otherwise: en_units=1 next cycle. en_tens=1 in the same cycle only if units_val is at the boundary value.
  - oneshot=0 at terminal gives a normal wrap to 00 (up) or FF (down).
- Latency: tick sampled at edge N -> en_units/en_tens high during the cycle after edge N, for one cycle. With start at edge 0, the first tick is at edge PRESCALE.
- Direction change:
  - dir_btn sets dir_pending.
  - forward toggles on the first edge where no tick is being processed, and dir_pending clears on that edge.
  - This guarantees that an enable pulse and its forward value are stable together.
  - dir_btn in the same cycle as a tick: the pulse carries the old direction, and forward flips one cycle later.
  - Two dir_btn pulses before they are applied cancel each other (dir_pending toggles).
- Simultaneous start_btn and tick in RUN: the tick is honoured (enables issued), then state -> PAUSE.
- running = (state==RUN); done = (state==DONE).
- An async reset mid-count returns to reset values immediately, with no enable glitch.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_PAUSE=2'd2, S_DONE=2'd3
  - UP_LIMIT=4'hF, DN_LIMIT=4'h0
- One natural sub-module: tick_prescaler. It has clk, reset, run, load0 and tick, and is parameterised by PRESCALE.
- The FSM, direction logic and cascade logic stay in the top.

Test Plan (PRESCALE=4):
- Reset held low, then released -> while held: cnt_clr=1, forward=1, en_units=0, running=0. First edge after release: cnt_clr=0.
- start_btn at edge 0, units_val=7 -> en_units pulses during the cycles after edges 4, 8, 12. en_tens stays 0. running=1.
- RUN, forward=1, units_val=F, tens_val=3 at tick -> en_units=1 and en_tens=1 in the same cycle. Repeat with forward=0, units_val=0 -> both pulse.
- start_btn at edge 2 after a RUN start, start_btn again at edge 10 -> PAUSE for edges 2..10, no enables. The first enable comes 2 cycles after resume (prescaler held at 2).
- oneshot=1, forward=1, units_val=F, tens_val=F at tick -> no enables, done=1. start_btn is ignored. clear_btn -> cnt_clr pulses 1 cycle, done=0, state IDLE.
- dir_btn coincident with tick (forward=1) -> en_units pulse with forward=1, then forward=0 one cycle later. Two dir_btn pulses on consecutive tick cycles -> forward unchanged.
